enoc_switch_allocator: RTL and testbench

ENOC_SWITCH_ALLOCATOR -- requirements
Module: enoc_switch_allocator

---
 rtl/enoc_switch_allocator_if.sv | 32 +++
 rtl/enoc_switch_allocator.sv | 107 ++++++++++
 tb/tb_enoc_switch_allocator.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enoc_switch_allocator_if.sv
// Switch-allocator handshake bundle: per-input requests/tails, per-output
// downstream ready, and the allocator's grant / crossbar select / valid outputs.
interface enoc_switch_allocator_if #(
    parameter int unsigned PORTS = 7
);
    logic [0:PORTS-1][0:PORTS-1] i_req;     // [input][output], one-hot per input
    logic [0:PORTS-1]            i_tail;    // per input
    logic [0:PORTS-1]            i_ready;   // per output
    logic [0:PORTS-1]            o_grant;   // per input
    logic [0:PORTS-1][0:PORTS-1] o_sel;     // [output][input], one-hot per output
    logic [0:PORTS-1]            o_out_val; // per output

    // Upstream side: route calculation, input buffers and downstream credit.
    modport master (
        output i_req,
        output i_tail,
        output i_ready,
        input  o_grant,
        input  o_sel,
        input  o_out_val
    );

    // Allocator side.
    modport slave (
        input  i_req,
        input  i_tail,
        input  i_ready,
        output o_grant,
        output o_sel,
        output o_out_val
    );
endinterface

// File: rtl/enoc_switch_allocator.sv
// Wormhole switch allocator: one lock FSM and round-robin pointer per output.
// Arbitration is registered; a locked output passes flits of its owner until
// the tail transfers, then spends one idle cycle re-arbitrating.
module enoc_switch_allocator #(
    parameter int unsigned PORTS = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    enoc_switch_allocator_if.slave bus
);
    localparam int unsigned PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef logic [PTR_W-1:0] idx_t;
    typedef enum logic {StIdle, StLocked} state_e;

    state_e           r_state      [PORTS];
    state_e           w_state_next [PORTS];
    idx_t             r_owner      [PORTS];
    idx_t             w_owner_next [PORTS];
    idx_t             r_ptr        [PORTS];
    idx_t             w_ptr_next   [PORTS];
    idx_t             w_winner     [PORTS];
    logic [PORTS-1:0] w_any_req;
    logic [PORTS-1:0] w_xfer;

    // Round-robin search per output: first requester at or after the pointer.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int j = 0; j < PORTS; j++) begin
            w_any_req[j] = 1'b0;
            w_winner[j]  = '0;
            for (int unsigned k = 0; k < PORTS; k++) begin
                idx = 32'(r_ptr[j]) + k;
                if (idx >= PORTS) begin
                    idx = idx - PORTS;
                end
                if (!w_any_req[j] && bus.i_req[idx_t'(idx)][j]) begin
                    w_any_req[j] = 1'b1;
                    w_winner[j]  = idx_t'(idx);
                end
            end
        end
    end

    // Crossbar select, transfer qualification and per-input grant.
    always_comb begin
        w_xfer        = '0;
        bus.o_sel     = '0;
        bus.o_out_val = '0;
        bus.o_grant   = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (r_state[j] == StLocked) begin
                // Select follows the lock even while downstream is stalled.
                bus.o_sel[j][r_owner[j]] = 1'b1;
                if (bus.i_req[r_owner[j]][j] && bus.i_ready[j]) begin
                    w_xfer[j]                = 1'b1;
                    bus.o_out_val[j]         = 1'b1;
                    bus.o_grant[r_owner[j]]  = 1'b1;
                end
            end
        end
    end

    // Per-output lock FSM next state and pointer update.
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            w_state_next[j] = r_state[j];
            w_owner_next[j] = r_owner[j];
            w_ptr_next[j]   = r_ptr[j];
            case (r_state[j])
                StIdle: begin
                    if (w_any_req[j]) begin
                        w_state_next[j] = StLocked;
                        w_owner_next[j] = w_winner[j];
                        w_ptr_next[j]   = (w_winner[j] == idx_t'(PORTS - 1)) ? '0
                                        : w_winner[j] + idx_t'(1);
                    end
                end
                StLocked: begin
                    // Only a tail transfer releases the lock.
                    if (w_xfer[j] && bus.i_tail[r_owner[j]]) begin
                        w_state_next[j] = StIdle;
                    end
                end
                default: w_state_next[j] = StIdle;
            endcase
        end
    end

    // State registers; reset drops every lock and rewinds the pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < PORTS; j++) begin
                r_state[j] <= StIdle;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                r_state[j] <= w_state_next[j];
                r_owner[j] <= w_owner_next[j];
                r_ptr[j]   <= w_ptr_next[j];
            end
        end
    end
endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed bench for enoc_switch_allocator: inputs are driven on the falling
// edge and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_enoc_switch_allocator;
    localparam int unsigned PORTS = 7;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    enoc_switch_allocator_if #(.PORTS(PORTS)) bus ();

    enoc_switch_allocator #(.PORTS(PORTS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Upstream contract: at most one output requested per input.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < PORTS; i++) begin
                assert ($onehot0(bus.i_req[i]))
                else $error("multi-hot request row on input %0d", i);
            end
        end
    end

    task automatic clear_inputs;
        bus.i_req   = '0;
        bus.i_tail  = '0;
        bus.i_ready = '1;
    endtask

    // Returns on a falling edge with reset just released.
    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.o_grant !== 7'b0) begin
            n_fail++; $display("FAIL reset_grant: got %b expected %b", bus.o_grant, 7'b0);
        end
        n_tests++;
        if (bus.o_sel !== '0) begin
            n_fail++; $display("FAIL reset_sel: got %h expected 0", bus.o_sel);
        end
        n_tests++;
        if (bus.o_out_val !== 7'b0) begin
            n_fail++; $display("FAIL reset_out_val: got %b expected %b", bus.o_out_val, 7'b0);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_flit;
        do_reset();
        bus.i_req[1]  = 7'b0010000;
        bus.i_tail[1] = 1'b1;
        #1;
        n_tests++;
        if (bus.o_out_val !== 7'b0) begin
            n_fail++; $display("FAIL single_latency: got %b expected %b", bus.o_out_val, 7'b0);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.o_sel[2] !== 7'b0100000) begin
            n_fail++; $display("FAIL single_sel2: got %b expected %b", bus.o_sel[2], 7'b0100000);
        end
        n_tests++;
        if (bus.o_out_val !== 7'b0010000) begin
            n_fail++; $display("FAIL single_out_val: got %b expected %b", bus.o_out_val, 7'b0010000);
        end
        n_tests++;
        if (bus.o_grant !== 7'b0100000) begin
            n_fail++; $display("FAIL single_grant: got %b expected %b", bus.o_grant, 7'b0100000);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (bus.o_sel[2] !== 7'b0) begin
            n_fail++; $display("FAIL single_idle_sel2: got %b expected %b", bus.o_sel[2], 7'b0);
        end
        n_tests++;
        if (bus.o_out_val !== 7'b0) begin
            n_fail++; $display("FAIL single_idle_out_val: got %b expected %b", bus.o_out_val, 7'b0);
        end
    endtask

    task automatic test_contention;
        logic [0:6] exp_g [8] = '{7'b0, 7'b1000000, 7'b0, 7'b0001000,
                                  7'b0, 7'b0000010, 7'b0, 7'b1000000};
        logic [0:6] exp_v;
        do_reset();
        bus.i_req[0] = 7'b0000001; bus.i_tail[0] = 1'b1;
        bus.i_req[3] = 7'b0000001; bus.i_tail[3] = 1'b1;
        bus.i_req[5] = 7'b0000001; bus.i_tail[5] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_v = (exp_g[c] != 7'b0) ? 7'b0000001 : 7'b0;
            n_tests++;
            if (bus.o_grant !== exp_g[c]) begin
                n_fail++;
                $display("FAIL contention_grant c%0d: got %b expected %b", c, bus.o_grant, exp_g[c]);
            end
            n_tests++;
            if (bus.o_out_val !== exp_v) begin
                n_fail++;
                $display("FAIL contention_out_val c%0d: got %b expected %b", c, bus.o_out_val, exp_v);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_wormhole;
        // Grant to input k and select of input k on output 1 share the same vector.
        logic [0:6] exp_gs [7] = '{7'b0, 7'b0000100, 7'b0000100, 7'b0000100,
                                   7'b0000100, 7'b0, 7'b0010000};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            bus.i_req[4]  = (c <= 4) ? 7'b0100000 : 7'b0;
            bus.i_req[2]  = (c >= 1) ? 7'b0100000 : 7'b0;
            bus.i_tail[4] = (c == 4);
            bus.i_tail[2] = 1'b1;
            #1;
            n_tests++;
            if (bus.o_grant !== exp_gs[c]) begin
                n_fail++;
                $display("FAIL wormhole_grant c%0d: got %b expected %b", c, bus.o_grant, exp_gs[c]);
            end
            n_tests++;
            if (bus.o_sel[1] !== exp_gs[c]) begin
                n_fail++;
                $display("FAIL wormhole_sel1 c%0d: got %b expected %b", c, bus.o_sel[1], exp_gs[c]);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.i_req[0] = 7'b0001000;
        #1;
        n_tests++;
        if (bus.o_out_val !== 7'b0) begin
            n_fail++; $display("FAIL bp_latency: got %b expected %b", bus.o_out_val, 7'b0);
        end
        @(negedge clk);
        bus.i_ready[3] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_tests++;
            if (bus.o_out_val !== 7'b0) begin
                n_fail++; $display("FAIL bp_out_val c%0d: got %b expected %b", c, bus.o_out_val, 7'b0);
            end
            n_tests++;
            if (bus.o_grant !== 7'b0) begin
                n_fail++; $display("FAIL bp_grant c%0d: got %b expected %b", c, bus.o_grant, 7'b0);
            end
            n_tests++;
            if (bus.o_sel[3] !== 7'b1000000) begin
                n_fail++; $display("FAIL bp_sel3 c%0d: got %b expected %b", c, bus.o_sel[3], 7'b1000000);
            end
            @(negedge clk);
        end
        bus.i_ready[3] = 1'b1;
        bus.i_tail[0]  = 1'b1;
        #1;
        n_tests++;
        if (bus.o_out_val !== 7'b0001000) begin
            n_fail++; $display("FAIL bp_resume_out_val: got %b expected %b", bus.o_out_val, 7'b0001000);
        end
        n_tests++;
        if (bus.o_grant !== 7'b1000000) begin
            n_fail++; $display("FAIL bp_resume_grant: got %b expected %b", bus.o_grant, 7'b1000000);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (bus.o_sel[3] !== 7'b0) begin
            n_fail++; $display("FAIL bp_release_sel3: got %b expected %b", bus.o_sel[3], 7'b0);
        end
    endtask

    task automatic test_wrap;
        logic [0:6] exp_g [4] = '{7'b0, 7'b0000001, 7'b0, 7'b1000000};
        do_reset();
        // Input 5 wins output 0 first, leaving its pointer at 6.
        bus.i_req[5]  = 7'b1000000;
        bus.i_tail[5] = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (bus.o_grant !== 7'b0000010) begin
            n_fail++; $display("FAIL wrap_setup_grant: got %b expected %b", bus.o_grant, 7'b0000010);
        end
        @(negedge clk);
        bus.i_req[5]  = 7'b0;
        bus.i_req[6]  = 7'b1000000; bus.i_tail[6] = 1'b1;
        bus.i_req[0]  = 7'b1000000; bus.i_tail[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (bus.o_grant !== exp_g[c]) begin
                n_fail++;
                $display("FAIL wrap_grant c%0d: got %b expected %b", c, bus.o_grant, exp_g[c]);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_parallel;
        do_reset();
        bus.i_req[0] = 7'b0100000; bus.i_tail[0] = 1'b1;
        bus.i_req[1] = 7'b0010000; bus.i_tail[1] = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (bus.o_grant !== 7'b1100000) begin
            n_fail++; $display("FAIL parallel_grant: got %b expected %b", bus.o_grant, 7'b1100000);
        end
        n_tests++;
        if (bus.o_out_val !== 7'b0110000) begin
            n_fail++; $display("FAIL parallel_out_val: got %b expected %b", bus.o_out_val, 7'b0110000);
        end
        n_tests++;
        if (bus.o_sel[1] !== 7'b1000000) begin
            n_fail++; $display("FAIL parallel_sel1: got %b expected %b", bus.o_sel[1], 7'b1000000);
        end
        n_tests++;
        if (bus.o_sel[2] !== 7'b0100000) begin
            n_fail++; $display("FAIL parallel_sel2: got %b expected %b", bus.o_sel[2], 7'b0100000);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        // Input 4 locks output 1 with a long packet; pointer moves to 5.
        bus.i_req[4] = 7'b0100000;
        @(negedge clk); #1;
        n_tests++;
        if (bus.o_sel[1] !== 7'b0000100) begin
            n_fail++; $display("FAIL async_locked_sel1: got %b expected %b", bus.o_sel[1], 7'b0000100);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.o_sel !== '0) begin
            n_fail++; $display("FAIL async_sel: got %h expected 0", bus.o_sel);
        end
        n_tests++;
        if (bus.o_out_val !== 7'b0) begin
            n_fail++; $display("FAIL async_out_val: got %b expected %b", bus.o_out_val, 7'b0);
        end
        n_tests++;
        if (bus.o_grant !== 7'b0) begin
            n_fail++; $display("FAIL async_grant: got %b expected %b", bus.o_grant, 7'b0);
        end
        @(negedge clk);
        // From ptr 0, input 2 beats input 6; a stale ptr of 5 would pick 6.
        bus.i_req[4]  = 7'b0;
        bus.i_req[2]  = 7'b0100000; bus.i_tail[2] = 1'b1;
        bus.i_req[6]  = 7'b0100000; bus.i_tail[6] = 1'b1;
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (bus.o_grant !== 7'b0) begin
            n_fail++; $display("FAIL async_post_latency: got %b expected %b", bus.o_grant, 7'b0);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.o_grant !== 7'b0010000) begin
            n_fail++; $display("FAIL async_post_grant: got %b expected %b", bus.o_grant, 7'b0010000);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_contention();
        test_wormhole();
        test_backpressure();
        test_wrap();
        test_parallel();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
